// File: rtl/alu_control_if.sv
// alu_control_if: decode inputs and decoded outputs of the RISC-V ALU-control
// decoder. The main control side (master) drives the instruction fields and
// alu_op. The decoder side (slave) returns the combinational and registered
// operation codes.
interface alu_control_if;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [1:0] alu_op;
  logic [3:0] control;
  logic       illegal;
  logic [3:0] control_q;
  logic       illegal_q;

  modport master (
    output funct7, funct3, alu_op,
    input  control, illegal, control_q, illegal_q
  );

  modport slave (
    input  funct7, funct3, alu_op,
    output control, illegal, control_q, illegal_q
  );
endinterface

// File: rtl/alu_control.sv
// alu_control: RISC-V ALU-control decoder for the multicycle datapath.
// It maps alu_op, funct3 and funct7 to a 4-bit ALU operation code. The
// decode is combinational. A registered copy is kept on clk, with a
// synchronous active-low reset.
// Build option ALUCTRL_EXT_OPS_EN enables XOR, SLL, SRL, SRA, SLT and SLTU.
// Without it, only ADD, SUB, AND and OR are produced, and any R/I-type
// funct3 in 001..101 is flagged illegal.
// An illegal encoding always yields ADD, so the ALU never sees an
// undefined code.
module alu_control (
  input  logic         clk,
  input  logic         rst_n,
  alu_control_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef ALUCTRL_EXT_OPS_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  logic [3:0] full_ctl;
  logic       full_ill;
  logic       ext_f3;

  // Full decode, as if the extended operations were always present.
  always_comb begin
    full_ctl = OP_ADD;
    full_ill = 1'b0;
    unique case (bus.alu_op)
      2'b00: full_ctl = OP_ADD;
      2'b01: full_ctl = OP_SUB;
      2'b10: begin
        if (bus.funct7 == F7_BASE) begin
          unique case (bus.funct3)
            3'b000: full_ctl = OP_ADD;
            3'b001: full_ctl = OP_SLL;
            3'b010: full_ctl = OP_SLT;
            3'b011: full_ctl = OP_SLTU;
            3'b100: full_ctl = OP_XOR;
            3'b101: full_ctl = OP_SRL;
            3'b110: full_ctl = OP_OR;
            3'b111: full_ctl = OP_AND;
          endcase
        end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b000) begin
          full_ctl = OP_SUB;
        end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b101) begin
          full_ctl = OP_SRA;
        end else begin
          full_ill = 1'b1;
        end
      end
      2'b11: begin
        // funct7 is immediate data except for the shift forms; ADDI is never SUB.
        unique case (bus.funct3)
          3'b000: full_ctl = OP_ADD;
          3'b001: begin
            if (bus.funct7 == F7_BASE) full_ctl = OP_SLL;
            else                       full_ill = 1'b1;
          end
          3'b010: full_ctl = OP_SLT;
          3'b011: full_ctl = OP_SLTU;
          3'b100: full_ctl = OP_XOR;
          3'b101: begin
            if (bus.funct7 == F7_BASE)     full_ctl = OP_SRL;
            else if (bus.funct7 == F7_ALT) full_ctl = OP_SRA;
            else                           full_ill = 1'b1;
          end
          3'b110: full_ctl = OP_OR;
          3'b111: full_ctl = OP_AND;
        endcase
      end
    endcase
  end

  assign ext_f3 = (bus.funct3 >= 3'b001) && (bus.funct3 <= 3'b101);

  // Drop the extended operations when the build leaves them out; illegal forces ADD.
  always_comb begin
    bus.illegal = full_ill | (bus.alu_op[1] & ext_f3 & ~EXT_EN);
    bus.control = bus.illegal ? OP_ADD : full_ctl;
  end

  // Registered copy of the decode; reset parks it on a legal ADD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.control_q <= OP_ADD;
      bus.illegal_q <= 1'b0;
    end else begin
      bus.control_q <= bus.control;
      bus.illegal_q <= bus.illegal;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed plus randomized checks of alu_control. A
// table-driven reference model, following the decode rules, supplies every
// expected value.
module tb_alu_control;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_control_if bus ();

  alu_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {illegal, control}
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3);
    logic [3:0] row [8];
    bit ext;
    row = '{4'd2, 4'd4, 4'd7, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
`ifdef ALUCTRL_EXT_OPS_EN
    ext = 1'b1;
`else
    ext = 1'b0;
`endif
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd6};
    if (!ext && f3 >= 3'd1 && f3 <= 3'd5) return {1'b1, 4'd2};
    if (op == 2'd2) begin
      if (f7 == 7'h00) return {1'b0, row[f3]};
      if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, 4'd6};
      if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 4'd8};
      return {1'b1, 4'd2};
    end
    if (f3 == 3'd1) return (f7 == 7'h00) ? {1'b0, 4'd4} : {1'b1, 4'd2};
    if (f3 == 3'd5) begin
      if (f7 == 7'h00) return {1'b0, 4'd5};
      if (f7 == 7'h20) return {1'b0, 4'd8};
      return {1'b1, 4'd2};
    end
    return {1'b0, row[f3]};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    bus.alu_op = op;
    bus.funct7 = f7;
    bus.funct3 = f3;
    #1;
  endtask

  logic [4:0] exp_q;
  logic [4:0] e;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(2'b10, 7'h00, 3'b111);

    // Directed combinational cases.
    drive(2'b00, 7'b0010100, 3'b110);
    check("ld_ctl", {4'd0, bus.control}, 8'h02);
    check("ld_ill", {7'd0, bus.illegal}, 8'h00);
    drive(2'b01, 7'b0010011, 3'b111);
    check("br_ctl", {4'd0, bus.control}, 8'h06);
    drive(2'b10, 7'h00, 3'b000);
    check("r_add", {4'd0, bus.control}, 8'h02);
    drive(2'b10, 7'h20, 3'b000);
    check("r_sub", {4'd0, bus.control}, 8'h06);
    drive(2'b10, 7'h00, 3'b111);
    check("r_and", {4'd0, bus.control}, 8'h00);
    drive(2'b10, 7'h00, 3'b110);
    check("r_or", {4'd0, bus.control}, 8'h01);
    drive(2'b11, 7'h20, 3'b000);
    check("addi_f7", {4'd0, bus.control}, 8'h02);
    check("addi_ill", {7'd0, bus.illegal}, 8'h00);
    drive(2'b10, 7'h01, 3'b000);
    check("r_bad_f7_ill", {7'd0, bus.illegal}, 8'h01);
    check("r_bad_f7_ctl", {4'd0, bus.control}, 8'h02);
    drive(2'b11, 7'h20, 3'b001);
    check("slli_bad_ill", {7'd0, bus.illegal}, 8'h01);
`ifdef ALUCTRL_EXT_OPS_EN
    drive(2'b10, 7'h20, 3'b101);
    check("r_sra", {4'd0, bus.control}, 8'h08);
    drive(2'b11, 7'h00, 3'b011);
    check("sltiu", {4'd0, bus.control}, 8'h09);
    drive(2'b10, 7'h00, 3'b100);
    check("r_xor", {4'd0, bus.control}, 8'h03);
`else
    drive(2'b10, 7'h00, 3'b100);
    check("noext_xor_ill", {7'd0, bus.illegal}, 8'h01);
    check("noext_xor_ctl", {4'd0, bus.control}, 8'h02);
    drive(2'b11, 7'h20, 3'b101);
    check("noext_srai_ill", {7'd0, bus.illegal}, 8'h01);
`endif

    // Registered path: two reset edges, then track, then a one-edge reset.
    drive(2'b10, 7'h00, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl_q", {4'd0, bus.control_q}, 8'h02);
    check("rst_ill_q", {7'd0, bus.illegal_q}, 8'h00);
    check("rst_comb_ctl", {4'd0, bus.control}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("q_and", {4'd0, bus.control_q}, 8'h00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ctl_q", {4'd0, bus.control_q}, 8'h02);
    rst_n = 1'b1;
    drive(2'b10, 7'h01, 3'b000);
    @(posedge clk);
    #1;
    check("q_ill", {7'd0, bus.illegal_q}, 8'h01);
    check("q_ill_ctl", {4'd0, bus.control_q}, 8'h02);

    // Randomized stimulus with occasional reset.
    exp_q = {1'b1, 4'd2};
    for (int i = 0; i < 400; i++) begin
      logic [6:0] f7;
      f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      rst_n = ($urandom_range(0, 15) != 0);
      drive(2'($urandom), f7, 3'($urandom));
      e = ref_decode(bus.alu_op, bus.funct7, bus.funct3);
      check("rnd_ctl", {4'd0, bus.control}, {4'd0, e[3:0]});
      check("rnd_ill", {7'd0, bus.illegal}, {7'd0, e[4]});
      exp_q = rst_n ? e : {1'b0, 4'd2};
      @(posedge clk);
      #1;
      check("rnd_ctl_q", {4'd0, bus.control_q}, {4'd0, exp_q[3:0]});
      check("rnd_ill_q", {7'd0, bus.illegal_q}, {7'd0, exp_q[4]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
